// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage:
//   PC_START      - default reset PC
//   INST_W/REG_W  - instruction and address widths
//   fetch_entry_t - one buffered instruction tagged with its PC
//   align_word    - clears the byte offset of a fetch target
// -----------------------------------------------------------------------------
package if_stage_pkg;

    localparam logic [63:0] PC_START = 64'h0000_0000_8000_0000;
    localparam int          INST_W   = 32;
    localparam int          REG_W    = 64;

    typedef struct packed {
        logic [REG_W-1:0]  addr;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Instructions are 4-byte aligned; the low two bits of a target are dropped.
    function automatic logic [REG_W-1:0] align_word(input logic [REG_W-1:0] a);
        return a & ~64'd3;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Bundles the instruction-bus and decode-side handshakes of the fetch stage.
//   master : the fetch stage (drives requests and the decode offer)
//   slave  : the environment (instruction bus and decode stage)
// Signals:
//   inst_req_valid/addr/ready  - fetch request channel
//   inst_resp_valid/data       - in-order instruction responses
//   id_valid/ready/inst/inst_addr - instruction offered to decode
// -----------------------------------------------------------------------------
interface if_stage_if;
    import if_stage_pkg::*;

    logic              inst_req_valid;
    logic [REG_W-1:0]  inst_req_addr;
    logic              inst_req_ready;
    logic              inst_resp_valid;
    logic [INST_W-1:0] inst_resp_data;
    logic              id_valid;
    logic              id_ready;
    logic [INST_W-1:0] id_inst;
    logic [REG_W-1:0]  id_inst_addr;

    modport master (
        output inst_req_valid, inst_req_addr,
        input  inst_req_ready,
        input  inst_resp_valid, inst_resp_data,
        output id_valid, id_inst, id_inst_addr,
        input  id_ready
    );

    modport slave (
        input  inst_req_valid, inst_req_addr,
        output inst_req_ready,
        output inst_resp_valid, inst_resp_data,
        input  id_valid, id_inst, id_inst_addr,
        output id_ready
    );

endinterface

// File: rtl/if_stage_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO with push/pop/flush and an occupancy count.
//   clk, rst   - clock, asynchronous active-low reset
//   push       - write push_data at the tail
//   pop        - advance the head
//   flush      - empty the FIFO (wins over push and pop)
//   head_data  - entry at the head (storage is not reset)
//   count      - number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage. Issues word-aligned fetch requests from the PC with
// up to DEPTH requests outstanding, tags in-order responses with their PC,
// buffers them and offers them to decode. A redirect reloads the PC, flushes
// the buffer and discards every response still in flight.
//   clk, rst        - clock, asynchronous active-low reset
//   bus             - if_stage_if.master (fetch bus + decode handshake)
//   redirect_valid  - taken branch/jump pulse from execute
//   redirect_pc     - new fetch target (byte offset ignored)
// -----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = PC_START,
    parameter int          DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    if_stage_if.master       bus,
    input  logic             redirect_valid,
    input  logic [REG_W-1:0] redirect_pc
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int SUM_W = CW + 1;
    localparam int ENT_W = REG_W + INST_W;

    logic [REG_W-1:0] pc_q, pc_d;
    logic [CW-1:0]    drop_cnt_q, drop_cnt_d;

    // The request-address FIFO holds exactly the accepted, unanswered
    // requests, so its occupancy is the in-flight count.
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    count;
    logic [REG_W-1:0] resp_addr;
    logic [ENT_W-1:0] head_raw;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    logic [SUM_W-1:0] credit_used;
    logic             credit_ok;
    logic             req_fire;
    logic             resp_fire;
    logic             resp_drop;
    logic             inst_push;
    logic             id_fire;

    assign credit_used = {1'b0, inflight} + {1'b0, count};
    assign credit_ok   = credit_used < SUM_W'(DEPTH);

    // rst gating forces the handshake outputs low while reset is held.
    assign bus.inst_req_valid = rst & credit_ok & ~redirect_valid;
    assign bus.inst_req_addr  = pc_q;
    assign req_fire           = bus.inst_req_valid & bus.inst_req_ready;

    assign resp_fire  = bus.inst_resp_valid & (inflight != '0);
    assign resp_drop  = resp_fire & (drop_cnt_q != '0);
    // A response landing in a redirect cycle is wrong-path and never buffered.
    assign inst_push  = resp_fire & ~resp_drop & ~redirect_valid;

    assign push_entry.addr = resp_addr;
    assign push_entry.inst = bus.inst_resp_data;

    assign bus.id_valid = rst & (count != '0) & ~redirect_valid;
    assign id_fire      = bus.id_valid & bus.id_ready;

    assign head             = fetch_entry_t'(head_raw);
    assign bus.id_inst      = (count != '0) ? head.inst : '0;
    assign bus.id_inst_addr = (count != '0) ? head.addr : '0;

    fetch_fifo #(.WIDTH(REG_W), .DEPTH(DEPTH)) u_req_addr_q (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (resp_fire),
        .flush     (1'b0),
        .head_data (resp_addr),
        .count     (inflight)
    );

    fetch_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inst_push),
        .push_data (push_entry),
        .pop       (id_fire),
        .flush     (redirect_valid),
        .head_data (head_raw),
        .count     (count)
    );

    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            pc_d = align_word(redirect_pc);
            // inflight already includes responses pending discard, so every
            // outstanding response except one answered now must be dropped.
            drop_cnt_d = inflight - {{(CW-1){1'b0}}, resp_fire};
        end else begin
            if (req_fire)  pc_d       = pc_q + 64'd4;
            if (resp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
